// File: rtl/me_pkg.sv
// Shared encodings and lane helpers for the memory-access stage.
package me_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  // Byte-lane enables for an access of the given size at byte offset off
  // (up to 8 lanes; narrower datapaths use the low bits).
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    case (size)
      SZ_B:    lane_mask = 8'h01 << off;
      SZ_H:    lane_mask = 8'h03 << off;
      SZ_W:    lane_mask = 8'h0F << off;
      default: lane_mask = 8'hFF;
    endcase
  endfunction

  // Sign/zero extension of a right-aligned load value.
  function automatic logic [63:0] extend(input logic [63:0] data, input logic [1:0] size,
                                         input logic sgn);
    case (size)
      SZ_B:    extend = {{56{sgn & data[7]}}, data[7:0]};
      SZ_H:    extend = {{48{sgn & data[15]}}, data[15:0]};
      SZ_W:    extend = {{32{sgn & data[31]}}, data[31:0]};
      default: extend = data;
    endcase
  endfunction

endpackage

// File: rtl/me_lane_align.sv
// Combinational lane handling: store byte enables and data replication,
// load lane extraction and extension, misalignment detection.
module me_lane_align
  import me_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]                    size,
  input  logic [$clog2(DATA_W/8)-1:0]   off,
  input  logic                          sgn,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [DATA_W-1:0]             rword,
  output logic [DATA_W/8-1:0]           be,
  output logic [DATA_W-1:0]             wrep,
  output logic [DATA_W-1:0]             rdata,
  output logic                          misalign
);

  localparam int NB = DATA_W / 8;

  logic [2:0]        off3;
  logic [2:0]        amask;
  logic [7:0]        mask8;
  logic [DATA_W-1:0] shifted;
  logic [63:0]       sh64;
  logic [63:0]       ext;

  always_comb begin
    off3 = 3'(off);
    case (size)
      SZ_B:    amask = 3'd0;
      SZ_H:    amask = 3'd1;
      SZ_W:    amask = 3'd3;
      default: amask = 3'd7;
    endcase
    misalign = (|(off3 & amask)) | ((size == SZ_D) && (DATA_W == 32));

    mask8 = lane_mask(size, off3);
    be    = mask8[NB-1:0];

    // Lane i carries store byte (i mod access-size), i.e. the data replicated.
    wrep = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      wrep[8*i +: 8] = wdata[8*(i & 32'(amask)) +: 8];
    end

    shifted           = rword >> {off, 3'b000};
    sh64              = '0;
    sh64[DATA_W-1:0]  = shifted;
    ext               = extend(sh64, size, sgn);
    rdata             = ext[DATA_W-1:0];
  end

endmodule

// File: rtl/me_stage_lsu.sv
// Memory-access stage with local data memory, multi-cycle load stall FSM
// and the ME/WB pipeline register.
module me_stage_lsu
  import me_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int LOAD_LAT = 1,
  parameter int REG_W    = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ValidM,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [1:0]        SizeM,
  input  logic              SignedM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic [REG_W-1:0]  WriteRegM,
  output logic              StallM,
  output logic              ValidW,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic              MisalignW,
  output logic [DATA_W-1:0] ALUResultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [REG_W-1:0]  WriteRegW
);

  localparam int NB   = DATA_W / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IDXW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [OFFW-1:0]   off;
  logic [IDXW-1:0]   idx;
  logic [DATA_W-1:0] rword, wrep, rdata;
  logic [NB-1:0]     be;
  logic              misalign;
  logic              mem_op, is_load, is_store, mem_we, stall;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;

  logic              valid_w_q, valid_w_d;
  logic              reg_write_w_q, reg_write_w_d;
  logic              mem_to_reg_w_q, mem_to_reg_w_d;
  logic              misalign_w_q, misalign_w_d;
  logic [DATA_W-1:0] alu_result_w_q, alu_result_w_d;
  logic [DATA_W-1:0] read_data_w_q, read_data_w_d;
  logic [REG_W-1:0]  write_reg_w_q, write_reg_w_d;

  assign off      = ALUResultM[OFFW-1:0];
  assign idx      = ALUResultM[OFFW +: IDXW];
  assign rword    = mem[idx];
  assign mem_op   = ValidM & (MemReadM | MemWriteM);
  assign is_store = ValidM & MemWriteM;
  assign is_load  = ValidM & MemReadM & ~MemWriteM;
  assign mem_we   = is_store & ~misalign;

  me_lane_align #(.DATA_W(DATA_W)) u_align (
    .size     (SizeM),
    .off      (off),
    .sgn      (SignedM),
    .wdata    (WriteDataM),
    .rword    (rword),
    .be       (be),
    .wrep     (wrep),
    .rdata    (rdata),
    .misalign (misalign)
  );

  // Byte-enabled store; contents survive reset.
  always_ff @(posedge Clock) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  // Load latency FSM: stall until the counter reaches LOAD_LAT-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_load && !misalign && (LOAD_LAT > 1)) begin
          stall   = 1'b1;
          cnt_d   = 3'd1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        stall = (cnt_q != 3'(LOAD_LAT - 1));
        cnt_d = cnt_q + 3'd1;
        if (!stall) begin
          cnt_d   = 3'd0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = 3'd0;
        state_d = IDLE;
      end
    endcase
  end

  // Reset aborts a pending load, so the stall is masked while it is asserted.
  assign StallM = stall & ~Reset;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ME/WB capture; bubble with held payload while stalled.
  always_comb begin
    valid_w_d      = valid_w_q;
    reg_write_w_d  = reg_write_w_q;
    mem_to_reg_w_d = mem_to_reg_w_q;
    misalign_w_d   = misalign_w_q;
    alu_result_w_d = alu_result_w_q;
    read_data_w_d  = read_data_w_q;
    write_reg_w_d  = write_reg_w_q;
    if (StallM) begin
      valid_w_d = 1'b0;
    end else begin
      valid_w_d      = ValidM;
      reg_write_w_d  = RegWriteM;
      mem_to_reg_w_d = MemtoRegM;
      misalign_w_d   = mem_op & misalign;
      alu_result_w_d = ALUResultM;
      read_data_w_d  = (is_load && !misalign) ? rdata : '0;
      write_reg_w_d  = WriteRegM;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      valid_w_q      <= 1'b0;
      reg_write_w_q  <= 1'b0;
      mem_to_reg_w_q <= 1'b0;
      misalign_w_q   <= 1'b0;
      alu_result_w_q <= '0;
      read_data_w_q  <= '0;
      write_reg_w_q  <= '0;
    end else begin
      valid_w_q      <= valid_w_d;
      reg_write_w_q  <= reg_write_w_d;
      mem_to_reg_w_q <= mem_to_reg_w_d;
      misalign_w_q   <= misalign_w_d;
      alu_result_w_q <= alu_result_w_d;
      read_data_w_q  <= read_data_w_d;
      write_reg_w_q  <= write_reg_w_d;
    end
  end

  assign ValidW     = valid_w_q;
  assign RegWriteW  = reg_write_w_q;
  assign MemtoRegW  = mem_to_reg_w_q;
  assign MisalignW  = misalign_w_q;
  assign ALUResultW = alu_result_w_q;
  assign ReadDataW  = read_data_w_q;
  assign WriteRegW  = write_reg_w_q;

endmodule

// File: tb/tb_me_stage_lsu.sv
// Bench for me_stage_lsu: three instances (LOAD_LAT 1 / 3 / 4+DEPTH 16),
// expected results queued at issue and compared at WB capture.
module tb_me_stage_lsu;

  typedef struct packed {
    logic        valid;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] alu;
    logic [31:0] wd;
    logic        regw;
    logic        m2r;
    logic [4:0]  wreg;
  } m_in_t;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] alu;
    logic        mis;
    logic [4:0]  wreg;
  } exp_t;

  logic        clk;
  logic        rst   [3];
  m_in_t       mi    [3];
  logic        stall [3];
  logic        vw    [3];
  logic        rww   [3];
  logic        m2rw  [3];
  logic        misw  [3];
  logic [31:0] aluw  [3];
  logic [31:0] rdw   [3];
  logic [4:0]  wregw [3];

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  me_stage_lsu #(.DATA_W(32), .DEPTH(1024), .LOAD_LAT(1), .REG_W(5)) u_lat1 (
    .Clock(clk), .Reset(rst[0]), .ValidM(mi[0].valid), .MemReadM(mi[0].rd),
    .MemWriteM(mi[0].wr), .SizeM(mi[0].size), .SignedM(mi[0].sgn),
    .ALUResultM(mi[0].alu), .WriteDataM(mi[0].wd), .RegWriteM(mi[0].regw),
    .MemtoRegM(mi[0].m2r), .WriteRegM(mi[0].wreg), .StallM(stall[0]),
    .ValidW(vw[0]), .RegWriteW(rww[0]), .MemtoRegW(m2rw[0]), .MisalignW(misw[0]),
    .ALUResultW(aluw[0]), .ReadDataW(rdw[0]), .WriteRegW(wregw[0])
  );

  me_stage_lsu #(.DATA_W(32), .DEPTH(1024), .LOAD_LAT(3), .REG_W(5)) u_lat3 (
    .Clock(clk), .Reset(rst[1]), .ValidM(mi[1].valid), .MemReadM(mi[1].rd),
    .MemWriteM(mi[1].wr), .SizeM(mi[1].size), .SignedM(mi[1].sgn),
    .ALUResultM(mi[1].alu), .WriteDataM(mi[1].wd), .RegWriteM(mi[1].regw),
    .MemtoRegM(mi[1].m2r), .WriteRegM(mi[1].wreg), .StallM(stall[1]),
    .ValidW(vw[1]), .RegWriteW(rww[1]), .MemtoRegW(m2rw[1]), .MisalignW(misw[1]),
    .ALUResultW(aluw[1]), .ReadDataW(rdw[1]), .WriteRegW(wregw[1])
  );

  me_stage_lsu #(.DATA_W(32), .DEPTH(16), .LOAD_LAT(4), .REG_W(5)) u_lat4 (
    .Clock(clk), .Reset(rst[2]), .ValidM(mi[2].valid), .MemReadM(mi[2].rd),
    .MemWriteM(mi[2].wr), .SizeM(mi[2].size), .SignedM(mi[2].sgn),
    .ALUResultM(mi[2].alu), .WriteDataM(mi[2].wd), .RegWriteM(mi[2].regw),
    .MemtoRegM(mi[2].m2r), .WriteRegM(mi[2].wreg), .StallM(stall[2]),
    .ValidW(vw[2]), .RegWriteW(rww[2]), .MemtoRegW(m2rw[2]), .MisalignW(misw[2]),
    .ALUResultW(aluw[2]), .ReadDataW(rdw[2]), .WriteRegW(wregw[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one instruction at a negedge, follow any stall, compare at capture.
  task automatic op(input string name, input int k, input logic rd, input logic wr,
                    input logic [1:0] sz, input logic sg, input logic [31:0] a,
                    input logic [31:0] wd, input logic [31:0] exp_rd,
                    input logic exp_mis, input int exp_stall);
    exp_t e;
    int   n;
    mi[k].valid = 1'b1;
    mi[k].rd    = rd;
    mi[k].wr    = wr;
    mi[k].size  = sz;
    mi[k].sgn   = sg;
    mi[k].alu   = a;
    mi[k].wd    = wd;
    mi[k].regw  = rd & ~wr;
    mi[k].m2r   = rd & ~wr;
    mi[k].wreg  = 5'($urandom_range(1, 31));
    e.rd   = exp_rd;
    e.alu  = a;
    e.mis  = exp_mis;
    e.wreg = mi[k].wreg;
    sb.push_back(e);
    #1;
    n = 0;
    while (stall[k] && n < 16) begin
      @(posedge clk); #1;
      n++;
      check($sformatf("%s.bubble", name), 32'(vw[k]), 32'd0);
    end
    if (stall[k]) check($sformatf("%s.stall_timeout", name), 32'd1, 32'd0);
    check($sformatf("%s.stall_cycles", name), 32'(n), 32'(exp_stall));
    @(posedge clk); #1;
    e = sb.pop_front();
    check($sformatf("%s.valid", name), 32'(vw[k]), 32'd1);
    check($sformatf("%s.rdata", name), rdw[k], e.rd);
    check($sformatf("%s.misalign", name), 32'(misw[k]), 32'(e.mis));
    check($sformatf("%s.alu", name), aluw[k], e.alu);
    check($sformatf("%s.wreg", name), 32'(wregw[k]), 32'(e.wreg));
    @(negedge clk);
    mi[k] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      mi[k]  = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst.stall", 32'(stall[k]), 32'd0);
      check("rst.valid", 32'(vw[k]), 32'd0);
      check("rst.rdata", rdw[k], 32'd0);
      check("rst.alu", aluw[k], 32'd0);
      check("rst.misalign", 32'(misw[k]), 32'd0);
      check("rst.regwrite", 32'(rww[k]), 32'd0);
      check("rst.memtoreg", 32'(m2rw[k]), 32'd0);
      check("rst.wreg", 32'(wregw[k]), 32'd0);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    @(negedge clk);

    // LOAD_LAT=1: sizes, extension, partial stores, misalignment
    op("sw10",   0, 0, 1, 2'b10, 0, 32'h10, 32'h8BADF00D, 32'h0,        0, 0);
    op("lb13",   0, 1, 0, 2'b00, 1, 32'h13, 32'h0,        32'hFFFFFF8B, 0, 0);
    op("lbu13",  0, 1, 0, 2'b00, 0, 32'h13, 32'h0,        32'h0000008B, 0, 0);
    op("lh10",   0, 1, 0, 2'b01, 1, 32'h10, 32'h0,        32'hFFFFF00D, 0, 0);
    op("lhu12",  0, 1, 0, 2'b01, 0, 32'h12, 32'h0,        32'h00008BAD, 0, 0);
    op("lb11",   0, 1, 0, 2'b00, 1, 32'h11, 32'h0,        32'hFFFFFFF0, 0, 0);
    op("sw20",   0, 0, 1, 2'b10, 0, 32'h20, 32'hAAAAAAAA, 32'h0,        0, 0);
    op("sh22",   0, 0, 1, 2'b01, 0, 32'h22, 32'h00001234, 32'h0,        0, 0);
    op("lw20a",  0, 1, 0, 2'b10, 0, 32'h20, 32'h0,        32'h1234AAAA, 0, 0);
    op("lw21",   0, 1, 0, 2'b10, 0, 32'h21, 32'h0,        32'h0,        1, 0);
    op("sw22",   0, 0, 1, 2'b10, 0, 32'h22, 32'hDEADBEEF, 32'h0,        1, 0);
    op("lw20b",  0, 1, 0, 2'b10, 0, 32'h20, 32'h0,        32'h1234AAAA, 0, 0);
    op("ld20",   0, 1, 0, 2'b11, 0, 32'h20, 32'h0,        32'h0,        1, 0);
    op("lh21",   0, 1, 0, 2'b01, 1, 32'h21, 32'h0,        32'h0,        1, 0);
    op("sb23",   0, 0, 1, 2'b00, 0, 32'h23, 32'hFFFFFF7F, 32'h0,        0, 0);
    op("lw20c",  0, 1, 0, 2'b10, 0, 32'h20, 32'h0,        32'h7F34AAAA, 0, 0);
    op("alu",    0, 0, 0, 2'b10, 0, 32'h12345678, 32'h0,  32'h0,        0, 0);
    op("rwsw30", 0, 1, 1, 2'b10, 0, 32'h30, 32'h0BADCAFE, 32'h0,        0, 0);
    op("lw30",   0, 1, 0, 2'b10, 0, 32'h30, 32'h0,        32'h0BADCAFE, 0, 0);
    @(posedge clk); #1;
    check("idle.valid", 32'(vw[0]), 32'd0);
    @(negedge clk);

    // LOAD_LAT=3: two-cycle stalls, back-to-back loads, misaligned no-stall
    op("l3sw0",  1, 0, 1, 2'b10, 0, 32'h0, 32'hCAFEBABE, 32'h0,        0, 0);
    op("l3lw0",  1, 1, 0, 2'b10, 0, 32'h0, 32'h0,        32'hCAFEBABE, 0, 2);
    op("l3lb3",  1, 1, 0, 2'b00, 1, 32'h3, 32'h0,        32'hFFFFFFCA, 0, 2);
    op("l3lw2",  1, 1, 0, 2'b10, 0, 32'h2, 32'h0,        32'h0,        1, 0);

    // DEPTH=16 / LOAD_LAT=4: index wrap and store-then-load
    op("l4sw40", 2, 0, 1, 2'b10, 0, 32'h40, 32'h00000055, 32'h0,        0, 0);
    op("l4lw0",  2, 1, 0, 2'b10, 0, 32'h0,  32'h0,        32'h00000055, 0, 3);
    op("l4sw8",  2, 0, 1, 2'b10, 0, 32'h8,  32'h00000099, 32'h0,        0, 0);
    op("l4lw8",  2, 1, 0, 2'b10, 0, 32'h8,  32'h0,        32'h00000099, 0, 3);
    op("l4sw4",  2, 0, 1, 2'b10, 0, 32'h4,  32'h11112222, 32'h0,        0, 0);

    // Reset during the second stall cycle of a pending load
    mi[2].valid = 1'b1;
    mi[2].rd    = 1'b1;
    mi[2].size  = 2'b10;
    mi[2].alu   = 32'h4;
    mi[2].wreg  = 5'd7;
    #1;
    check("rstmid.stall1", 32'(stall[2]), 32'd1);
    @(posedge clk); #1;
    check("rstmid.stall2", 32'(stall[2]), 32'd1);
    check("rstmid.held_alu", aluw[2], 32'h4);
    rst[2] = 1'b1;
    #1;
    check("rstmid.stall", 32'(stall[2]), 32'd0);
    check("rstmid.valid", 32'(vw[2]), 32'd0);
    check("rstmid.alu", aluw[2], 32'd0);
    check("rstmid.rdata", rdw[2], 32'd0);
    check("rstmid.misalign", 32'(misw[2]), 32'd0);
    check("rstmid.wreg", 32'(wregw[2]), 32'd0);
    @(negedge clk);
    mi[2] = '0;
    @(negedge clk);
    rst[2] = 1'b0;
    @(negedge clk);
    op("l4lw4", 2, 1, 0, 2'b10, 0, 32'h4, 32'h0, 32'h11112222, 0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/me_stage_lsu.md
Name: me_stage_lsu

Overview:
Parametrised memory-access stage: the next generation of the single-word ME stage plus ME/WB register. Adds byte/half/word (and dword when DATA_W=64) loads and stores, sign/zero extension, misalignment detection, and a configurable multi-cycle load latency with a stall handshake. Sits between the EX/ME register and the WB stage. Contains its own data memory array and the ME/WB pipeline register.

Parameters:
DATA_W, 32, datapath width; 32 or 64 only.
DEPTH, 1024, memory depth in DATA_W-bit words; power of two.
LOAD_LAT, 1, cycles from load presentation to WB capture; 1..8; 1 means no stall.
REG_W, 5, register-index width.

Ports:
Clock  in  1  rising-edge clock.
Reset  in  1  asynchronous, active-high reset.
ValidM  in  1  instruction present in ME this cycle.
MemReadM  in  1  load request.
MemWriteM  in  1  store request; MemReadM&MemWriteM both 1 is treated as a store.
SizeM  in  2  00 byte, 01 half, 10 word, 11 dword (legal only if DATA_W=64).
SignedM  in  1  1 = sign-extend the load result, 0 = zero-extend.
ALUResultM  in  DATA_W  byte address (loads/stores) or pass-through result.
WriteDataM  in  DATA_W  store data, right-aligned.
RegWriteM, MemtoRegM  in  1 each  control passed through to WB.
WriteRegM  in  REG_W  destination register.
StallM  out  1  combinational; upstream must hold all M inputs stable while high.
ValidW, RegWriteW, MemtoRegW, MisalignW  out  1 each  registered.
ALUResultW, ReadDataW  out  DATA_W  registered.
WriteRegW  out  REG_W  registered.

Behaviour:
- Reset (async): all W outputs 0, FSM IDLE, latency counter 0. Memory contents are not cleared. A reset asserted mid-stall aborts the load; StallM drops immediately.
- Address split: OFF = ALUResultM[log2(DATA_W/8)-1:0]; word index = next log2(DEPTH) bits; higher bits ignored, so the index wraps modulo DEPTH.
- Misaligned access: OFF not a multiple of the access size, or SizeM=11 with DATA_W=32. The store is suppressed, the load returns 0 with no stall, and MisalignW=1 for that instruction. The instruction still retires with ValidW=1.
- Store: byte-lane write enables are derived from SizeM and OFF; data is replicated into the lanes. The write happens at the posedge where ValidM&MemWriteM holds and the access is aligned. A store never stalls.
- Load: the word is read and the addressed lane extracted, shifted to bit 0, then sign- or zero-extended per SignedM.
- FSM states IDLE and WAIT; counter cnt of width 3.
  - IDLE: an aligned load with LOAD_LAT>1 makes StallM=1; cnt goes to 1 and the FSM goes to WAIT.
  - WAIT: StallM = (cnt != LOAD_LAT-1). The counter increments each cycle. When StallM=0, the result is captured and the FSM returns to IDLE with cnt=0.
- ME/WB register: captures all W outputs at a posedge when StallM=0. While StallM=1, ValidW=0 (bubble) and the other W outputs hold their values.
- ValidM=0: no memory access, no stall, and ValidW=0 on the next cycle.
- Store followed by a load to the same word on consecutive cycles: the load returns the new data (write-first ordering).
- Non-memory instruction: ReadDataW=0 and ALUResultW=ALUResultM.

Decomposition:
- Package me_pkg holds:
  - the size encoding constants (SZ_B, SZ_H, SZ_W, SZ_D);
  - the FSM state enum;
  - the function lane_mask(size, off);
  - the function extend(data, size, signed).
- One sub-module, me_lane_align, covers store lane mask and data replication, load lane extraction and extension, and the misalignment flag. It is purely combinational.

Test Plan:
1. DATA_W=32: store word 0x8BADF00D at 0x10, then lb at 0x13 with SignedM=1 -> ReadDataW=0xFFFFFF8B; lbu at 0x13 -> 0x0000008B; lh at 0x10 with SignedM=1 -> 0xFFFFF00D.
2. sh 0x1234 at 0x22 over an existing word 0xAAAAAAAA at 0x20, then lw 0x20 -> 0x1234AAAA.
3. lw at 0x21 -> MisalignW=1, ReadDataW=0, no stall. sw at 0x22 -> memory unchanged and MisalignW=1.
4. LOAD_LAT=3: aligned lw -> StallM high for exactly 2 cycles, ValidW=0 during those cycles, data valid with ValidW=1 on the 3rd edge. A back-to-back second lw stalls again for 2 cycles.
5. LOAD_LAT=4: assert Reset during the 2nd stall cycle -> StallM=0 immediately, all W outputs 0. After release, a fresh lw completes correctly.
6. DEPTH=16: sw 0x55 at byte address 0x40 (index wraps to 0), then lw 0x0 -> 0x00000055. Also sw then lw to the same address on consecutive cycles -> new value returned.
